// File: rtl/uart_tx_buffer_if.sv
// ============================================================================
// uart_tx_buffer_if : push-side and line-side signals of the UART TX buffer
// Revision 1.0
// ============================================================================
`default_nettype none

interface uart_tx_buffer_if #(
  parameter int ADDR_W = 4
) ();
  logic              wr_en;
  logic [7:0]        wr_data;
  logic              tx_ready;
  logic              txd;
  logic              busy;
  logic [ADDR_W:0]   count;
  logic              overflow;

  modport master (
    output wr_en, wr_data,
    input  tx_ready, txd, busy, count, overflow
  );

  modport slave (
    input  wr_en, wr_data,
    output tx_ready, txd, busy, count, overflow
  );
endinterface

`default_nettype wire

// File: rtl/uart_tx_buffer.sv
// ============================================================================
// uart_tx_buffer : byte FIFO drained by a UART 8N1 serializer onto txd
// Revision 1.0
// ============================================================================
`default_nettype none

module uart_tx_buffer #(
  parameter int CLKS_PER_BIT = 868,
  parameter int DEPTH        = 16,
  parameter int ADDR_W       = 4
) (
  input  wire logic          clk,
  input  wire logic          rst,
  uart_tx_buffer_if.slave    bus
);

  localparam int              BAUD_W    = $clog2(CLKS_PER_BIT);
  localparam logic [BAUD_W-1:0] BAUD_LAST = BAUD_W'(CLKS_PER_BIT - 1);
  localparam logic [ADDR_W:0] FULL_CNT  = (ADDR_W + 1)'(DEPTH);

  typedef enum logic [1:0] {
    IDLE  = 2'd0,
    START = 2'd1,
    DATA  = 2'd2,
    STOP  = 2'd3
  } state_t;

  state_t              state;
  state_t              next_state;
  logic [7:0]          mem [DEPTH];
  logic [ADDR_W-1:0]   wr_ptr;
  logic [ADDR_W-1:0]   rd_ptr;
  logic [ADDR_W:0]     count;
  logic                overflow;
  logic [BAUD_W-1:0]   baud_cnt;
  logic [2:0]          bit_idx;
  logic [7:0]          shift;
  logic                txd;

  logic                not_full;
  logic                not_empty;
  logic                push;
  logic                pop;
  logic                baud_last;

  assign not_full  = (count != FULL_CNT);
  assign not_empty = (count != '0);
  assign push      = bus.wr_en && not_full;
  assign baud_last = (baud_cnt == BAUD_LAST);

  assign bus.tx_ready = not_full;
  assign bus.txd      = txd;
  assign bus.busy     = (state != IDLE) || not_empty;
  assign bus.count    = count;
  assign bus.overflow = overflow;

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      state <= IDLE;
    end else begin
      state <= next_state;
    end
  end

  // Popping from STOP on its last cycle gives back-to-back frames.
  always_comb begin
    next_state = state;
    pop        = 1'b0;
    case (state)
      IDLE: begin
        if (not_empty) begin
          pop        = 1'b1;
          next_state = START;
        end
      end
      START: begin
        if (baud_last) next_state = DATA;
      end
      DATA: begin
        if (baud_last && bit_idx == 3'd7) next_state = STOP;
      end
      STOP: begin
        if (baud_last) begin
          if (not_empty) begin
            pop        = 1'b1;
            next_state = START;
          end else begin
            next_state = IDLE;
          end
        end
      end
      default: next_state = IDLE;
    endcase
  end

  always_ff @(posedge clk) begin
    if (push) mem[wr_ptr] <= bus.wr_data;
  end

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      wr_ptr   <= '0;
      rd_ptr   <= '0;
      count    <= '0;
      overflow <= 1'b0;
    end else begin
      if (push) wr_ptr <= wr_ptr + 1'b1;
      if (pop)  rd_ptr <= rd_ptr + 1'b1;
      if (push && !pop)      count <= count + 1'b1;
      else if (pop && !push) count <= count - 1'b1;
      if (bus.wr_en && !not_full) overflow <= 1'b1;
    end
  end

  // txd is updated together with the bit it announces, so it stays registered.
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      baud_cnt <= '0;
      bit_idx  <= '0;
      shift    <= '0;
      txd      <= 1'b1;
    end else if (pop) begin
      shift    <= mem[rd_ptr];
      baud_cnt <= '0;
      bit_idx  <= '0;
      txd      <= 1'b0;
    end else if (state != IDLE) begin
      if (baud_last) begin
        baud_cnt <= '0;
        case (state)
          START: begin
            bit_idx <= '0;
            txd     <= shift[0];
          end
          DATA: begin
            if (bit_idx == 3'd7) begin
              txd <= 1'b1;
            end else begin
              shift   <= shift >> 1;
              bit_idx <= bit_idx + 1'b1;
              txd     <= shift[1];
            end
          end
          default: txd <= 1'b1;
        endcase
      end else begin
        baud_cnt <= baud_cnt + 1'b1;
      end
    end
  end

endmodule

`default_nettype wire
